fp_div_sqrt_lane_ctrl: RTL

- Per-lane reservation and handshake controller for the FP divide/square-root unit.
- Sits between the FP issue queue, the FP execution stage and the iterative FP32 div/sqrt arithmetic cores, one core per lane.
- Arbitrates ownership of each lane's core so that exactly one div/sqrt op owns it from issue until the execution stage collects the result.
- Handles selective-flush aborts from the recovery manager.

---
 rtl/fp_div_sqrt_lane_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fp_div_sqrt_lane_ctrl.sv
// Per-lane ownership/handshake controller for the FP32 div/sqrt cores: one op owns a lane from acquire to release.
// Latency: req->core_start 1 cycle, core_done->finished 1 cycle, release->free 1 cycle; no backpressure, the issue queue waits on free.
module fp_div_sqrt_lane_ctrl #(
    parameter int LANES        = 1,
    parameter int DATA_WIDTH   = 32,
    parameter int FFLAGS_WIDTH = 5,
    parameter int RM_WIDTH     = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [LANES-1:0]                acquire,
    output logic [LANES-1:0]                free,
    output logic [LANES-1:0]                reserved,
    input  logic [LANES-1:0]                req,
    input  logic [LANES*DATA_WIDTH-1:0]     data_a_in,
    input  logic [LANES*DATA_WIDTH-1:0]     data_b_in,
    input  logic [LANES-1:0]                is_divide,
    input  logic [LANES*RM_WIDTH-1:0]       rm_in,
    output logic [LANES-1:0]                finished,
    output logic [LANES*DATA_WIDTH-1:0]     data_out,
    output logic [LANES*FFLAGS_WIDTH-1:0]   fflags_out,
    input  logic [LANES-1:0]                release_req,
    input  logic [LANES-1:0]                flush,
    output logic [LANES-1:0]                core_start,
    output logic [LANES*DATA_WIDTH-1:0]     core_a,
    output logic [LANES*DATA_WIDTH-1:0]     core_b,
    output logic [LANES-1:0]                core_is_divide,
    output logic [LANES*RM_WIDTH-1:0]       core_rm,
    output logic [LANES-1:0]                core_kill,
    input  logic [LANES-1:0]                core_done,
    input  logic [LANES*DATA_WIDTH-1:0]     core_result,
    input  logic [LANES*FFLAGS_WIDTH-1:0]   core_fflags
);

    typedef enum logic [2:0] {
        S_FREE,
        S_RESERVED,
        S_START,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state_q [LANES];
    state_t           state_d [LANES];
    logic [LANES-1:0] latch_ops;
    logic [LANES-1:0] latch_res;
    logic [LANES-1:0] kill_d;

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (rst) state_q[i] <= S_FREE;
            else     state_q[i] <= state_d[i];
        end
    end

    // Flush outranks every other event in all owned states.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            state_d[i]   = state_q[i];
            latch_ops[i] = 1'b0;
            latch_res[i] = 1'b0;
            kill_d[i]    = 1'b0;
            free[i]      = (state_q[i] == S_FREE);
            reserved[i]  = (state_q[i] != S_FREE);
            finished[i]  = (state_q[i] == S_DONE);
            core_start[i] = (state_q[i] == S_START);
            case (state_q[i])
                S_FREE: begin
                    if (acquire[i]) state_d[i] = S_RESERVED;
                end
                S_RESERVED: begin
                    if (flush[i]) begin
                        state_d[i] = S_FREE;
                    end else if (req[i]) begin
                        state_d[i]   = S_START;
                        latch_ops[i] = 1'b1;
                    end
                end
                S_START: begin
                    if (flush[i]) begin
                        state_d[i] = S_FREE;
                        kill_d[i]  = 1'b1;
                    end else if (core_done[i]) begin
                        state_d[i]   = S_DONE;
                        latch_res[i] = 1'b1;
                    end else begin
                        state_d[i] = S_BUSY;
                    end
                end
                S_BUSY: begin
                    // A flush racing core_done needs no kill: the core is already idle.
                    if (flush[i]) begin
                        state_d[i] = S_FREE;
                        kill_d[i]  = !core_done[i];
                    end else if (core_done[i]) begin
                        state_d[i]   = S_DONE;
                        latch_res[i] = 1'b1;
                    end
                end
                S_DONE: begin
                    if (flush[i] || release_req[i]) state_d[i] = S_FREE;
                end
                default: state_d[i] = S_FREE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_a         <= '0;
            core_b         <= '0;
            core_is_divide <= '0;
            core_rm        <= '0;
            core_kill      <= '0;
            data_out       <= '0;
            fflags_out     <= '0;
        end else begin
            core_kill <= kill_d;
            for (int i = 0; i < LANES; i++) begin
                if (latch_ops[i]) begin
                    core_a[i*DATA_WIDTH +: DATA_WIDTH] <= data_a_in[i*DATA_WIDTH +: DATA_WIDTH];
                    core_b[i*DATA_WIDTH +: DATA_WIDTH] <= data_b_in[i*DATA_WIDTH +: DATA_WIDTH];
                    core_is_divide[i]                  <= is_divide[i];
                    core_rm[i*RM_WIDTH +: RM_WIDTH]    <= rm_in[i*RM_WIDTH +: RM_WIDTH];
                end
                if (latch_res[i]) begin
                    data_out[i*DATA_WIDTH +: DATA_WIDTH]       <= core_result[i*DATA_WIDTH +: DATA_WIDTH];
                    fflags_out[i*FFLAGS_WIDTH +: FFLAGS_WIDTH] <= core_fflags[i*FFLAGS_WIDTH +: FFLAGS_WIDTH];
                end
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_proto
        a_acquire: assert property (@(posedge clk) disable iff (rst)
            acquire[g] |-> state_q[g] == S_FREE);
        a_req: assert property (@(posedge clk) disable iff (rst)
            req[g] |-> state_q[g] == S_RESERVED);
        a_release: assert property (@(posedge clk) disable iff (rst)
            release_req[g] |-> state_q[g] == S_DONE);
        // A killed core may still emit one late done while the lane sits idle.
        a_done: assert property (@(posedge clk) disable iff (rst)
            core_done[g] |-> state_q[g] inside {S_START, S_BUSY, S_FREE});
    end

endmodule
